// File: rtl/usbf_ep_tx_packetizer.sv
// USB device TX packetizer: emits PID, payload popped from the endpoint FIFO, then CRC16 to UTMI.
// Optional macro USBF_TX_BYTE_CNT_EN adds tx_bytes_o, the count of payload bytes sent in the last packet.
module usbf_ep_tx_packetizer #(
  parameter int MAX_PKT = 64,
  parameter int LEN_W   = 7
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             start_i,
  input  logic [3:0]       pid_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             underrun_o,
  input  logic [7:0]       fifo_data_i,
  input  logic             fifo_empty_i,
  output logic             fifo_pop_o,
  output logic [7:0]       utmi_data_o,
  output logic             utmi_txvalid_o,
  input  logic             utmi_txready_i
`ifdef USBF_TX_BYTE_CNT_EN
  ,
  output logic [LEN_W-1:0] tx_bytes_o
`endif
);

  typedef enum logic [2:0] {ST_IDLE, ST_PID, ST_DATA, ST_CRC_LO, ST_CRC_HI} state_e;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT);

  state_e           state_q, state_d;
  logic [3:0]       pid_q, pid_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [15:0]      crc_q, crc_d;
  logic             done_q, done_d;
  logic             underrun_q, underrun_d;
`ifdef USBF_TX_BYTE_CNT_EN
  logic [LEN_W-1:0] tx_bytes_q, tx_bytes_d;
`endif

  // Reflected CRC16 (0xA001), one byte shifted in LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
    state_d        = state_q;
    pid_d          = pid_q;
    rem_d          = rem_q;
    crc_d          = crc_q;
    done_d         = 1'b0;
    underrun_d     = 1'b0;
`ifdef USBF_TX_BYTE_CNT_EN
    tx_bytes_d     = tx_bytes_q;
`endif
    utmi_txvalid_o = 1'b0;
    utmi_data_o    = 8'h00;
    fifo_pop_o     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          pid_d   = pid_i;
          rem_d   = (len_i > MAX_LEN) ? MAX_LEN : len_i;
          crc_d   = 16'hFFFF;
          state_d = ST_PID;
`ifdef USBF_TX_BYTE_CNT_EN
          tx_bytes_d = '0;
`endif
        end
      end
      ST_PID: begin
        utmi_txvalid_o = 1'b1;
        utmi_data_o    = {~pid_q, pid_q};
        if (utmi_txready_i) state_d = (rem_q != '0) ? ST_DATA : ST_CRC_LO;
      end
      ST_DATA: begin
        if (!fifo_empty_i) begin
          utmi_txvalid_o = 1'b1;
          utmi_data_o    = fifo_data_i;
          fifo_pop_o     = utmi_txready_i;
          if (utmi_txready_i) begin
            rem_d = rem_q - LEN_W'(1);
            crc_d = crc16_byte(crc_q, fifo_data_i);
`ifdef USBF_TX_BYTE_CNT_EN
            tx_bytes_d = tx_bytes_q + LEN_W'(1);
`endif
            if (rem_q == LEN_W'(1)) state_d = ST_CRC_LO;
          end
        end else begin
          // FIFO starved mid-payload: abandon the packet rather than stall the bus.
          state_d    = ST_IDLE;
          underrun_d = 1'b1;
        end
      end
      ST_CRC_LO: begin
        utmi_txvalid_o = 1'b1;
        utmi_data_o    = ~crc_q[7:0];
        if (utmi_txready_i) state_d = ST_CRC_HI;
      end
      ST_CRC_HI: begin
        utmi_txvalid_o = 1'b1;
        utmi_data_o    = ~crc_q[15:8];
        if (utmi_txready_i) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q    <= ST_IDLE;
      pid_q      <= 4'h0;
      rem_q      <= '0;
      crc_q      <= 16'hFFFF;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
`ifdef USBF_TX_BYTE_CNT_EN
      tx_bytes_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pid_q      <= pid_d;
      rem_q      <= rem_d;
      crc_q      <= crc_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
`ifdef USBF_TX_BYTE_CNT_EN
      tx_bytes_q <= tx_bytes_d;
`endif
    end
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = done_q;
  assign underrun_o = underrun_q;
`ifdef USBF_TX_BYTE_CNT_EN
  assign tx_bytes_o = tx_bytes_q;
`endif

endmodule
